// File: rtl/fpcvt_pkg.sv
// Shared types and constants for the sequential two's-complement to
// small-float converter.
package fpcvt_pkg;

  localparam int TC_W = 12;
  localparam int SM_W = 11;
  localparam int E_W  = 3;
  localparam int F_W  = 4;

  localparam logic [E_W-1:0]  E_MAX    = 3'd7;
  localparam logic [F_W-1:0]  F_MAX    = 4'd15;
  localparam logic [F_W-1:0]  F_RENORM = 4'd8;
  localparam logic [TC_W-1:0] TC_MIN   = 12'h800;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fpcvt_tctsm.sv
// Two's-complement to sign-magnitude. The most negative code has no
// 11-bit magnitude, so it clamps to the largest one (2047).
module fpcvt_tctsm
  import fpcvt_pkg::*;
(
  input  logic [TC_W-1:0] tc,
  output logic            sign,
  output logic [SM_W-1:0] mag
);

  // Negate negative inputs, clamp the one unrepresentable code.
  always_comb begin
    sign = tc[TC_W-1];
    mag  = tc[SM_W-1:0];
    if (tc == TC_MIN) begin
      mag = '1;
    end else if (tc[TC_W-1]) begin
      mag = ~tc[SM_W-1:0] + 11'd1;
    end
  end

endmodule

// File: rtl/fpcvt_seq.sv
// Sequential converter: 12-bit two's complement -> sign, 3-bit exponent,
// 4-bit significand (value = F * 2^E), one bit-shift per NORM cycle.
//
// Handshake: a sample is taken on a clock edge where in_valid && in_ready;
// in_ready is high only in IDLE and never while rst_n is low. A result is
// presented with out_valid high and held unchanged until an edge where
// out_ready is high; out_ready while out_valid is low is ignored.
module fpcvt_seq
  import fpcvt_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [TC_W-1:0] in_tc,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_s,
  output logic [E_W-1:0]  out_e,
  output logic [F_W-1:0]  out_f,
  output logic            out_sat,
  output state_t          dbg_state
);

  state_t          state, state_nxt;
  logic [SM_W-1:0] sh;
  logic [E_W-1:0]  e;
  logic            s;
  logic            sat_in;

  logic            tc_sign;
  logic [SM_W-1:0] tc_mag;

  logic [F_W-1:0]  f_trunc;
  logic            r_bit;
  logic            norm_done;
  logic [F_W-1:0]  rnd_f;
  logic [E_W-1:0]  rnd_e;
  logic            rnd_sat;

  fpcvt_tctsm u_tctsm (
    .tc   (in_tc),
    .sign (tc_sign),
    .mag  (tc_mag)
  );

  assign in_ready  = (state == IDLE) && rst_n;
  assign dbg_state = state;

  // Next-state decode and round-to-nearest of the normalised significand.
  always_comb begin
    state_nxt = state;
    f_trunc   = sh[SM_W-1:SM_W-F_W];
    r_bit     = sh[SM_W-F_W-1];
    norm_done = sh[SM_W-1] || (e == '0);
    rnd_f     = f_trunc;
    rnd_e     = e;
    rnd_sat   = 1'b0;

    if (r_bit) begin
      if (f_trunc != F_MAX) begin
        rnd_f = f_trunc + 4'd1;
      end else if (e != E_MAX) begin
        rnd_f = F_RENORM;
        rnd_e = e + 3'd1;
      end else begin
        rnd_f   = F_MAX;
        rnd_sat = 1'b1;
      end
    end

    case (state)
      IDLE:    if (in_valid)  state_nxt = NORM;
      NORM:    if (norm_done) state_nxt = ROUND;
      ROUND:                  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Datapath: capture, shift-normalise, register the rounded result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh        <= '0;
      e         <= '0;
      s         <= 1'b0;
      sat_in    <= 1'b0;
      out_valid <= 1'b0;
      out_s     <= 1'b0;
      out_e     <= '0;
      out_f     <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sh     <= tc_mag;
            e      <= E_MAX;
            s      <= tc_sign;
            sat_in <= (in_tc == TC_MIN);
          end
        end
        NORM: begin
          if (!norm_done) begin
            sh <= {sh[SM_W-2:0], 1'b0};
            e  <= e - 3'd1;
          end
        end
        ROUND: begin
          out_s     <= s;
          out_e     <= rnd_e;
          out_f     <= rnd_f;
          out_sat   <= sat_in || rnd_sat;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fpcvt_seq.md
FPCVT_SEQ -- requirements
Module: fpcvt_seq

Interface
REQ-001 Parameters: none; all widths come from package constants.
REQ-002 Clocking: one clock, clk; reset rst_n is synchronous and active-low.
REQ-003 clk        input   1    rising-edge clock for all state.
REQ-004 rst_n      input   1    synchronous active-low reset.
REQ-005 in_valid   input   1    in_tc holds a sample to convert.
REQ-006 in_tc      input   12   two's-complement sample.
REQ-007 in_ready   output  1    block can accept a sample; 1 only in IDLE.
REQ-008 out_valid  output  1    out_s/out_e/out_f/out_sat hold a result.
REQ-009 out_ready  input   1    consumer takes the result.
REQ-010 out_s      output  1    result sign.
REQ-011 out_e      output  3    result exponent, 0..7.
REQ-012 out_f      output  4    result significand; value = F * 2^E.
REQ-013 out_sat    output  1    result was saturated.

Function
REQ-014 States: IDLE, NORM, ROUND, DONE.
REQ-015 Accept handshake: accept when in_valid && in_ready at a clk edge.
- sh <= 11-bit sign-magnitude of in_tc (0x800 maps to 2047).
- e <= 7; s <= in_tc[11]; sat_in <= (in_tc == 0x800); state <= NORM.
REQ-016 NORM, one cycle per step:
- if sh[10]==1 or e==0: go to ROUND;
- else sh <= sh<<1 with zero fill, e <= e-1, stay in NORM.
REQ-017 ROUND, with f = sh[10:7] and round bit r = sh[6]:
- r==0: out_f = f, out_e = e.
- r==1, f<15: out_f = f+1, out_e = e.
- r==1, f==15, e<7: out_f = 8, out_e = e+1.
- r==1, f==15, e==7: out_f = 15, out_e = 7, saturation.
- Then out_s = s, out_sat = sat_in OR saturation, out_valid <= 1, state <= DONE.
REQ-018 DONE: hold all outputs stable until out_ready==1, then out_valid <= 0 and state <= IDLE; earliest re-accept is the following edge.
REQ-019 Latency: with k = number of shifts (0..7), out_valid rises k+2 edges after the accept edge; best case 2, worst case 9.
REQ-020 Throughput: one conversion in flight; in_ready==0 in NORM, ROUND and DONE; in_tc is ignored outside accept.
REQ-021 Zero input: 0x000 gives out_s=0, out_e=0, out_f=0, out_sat=0 after 9 cycles.
REQ-022 Output stability: out_s, out_e, out_f and out_sat change only on the ROUND->DONE edge or on reset.
REQ-023 out_ready while out_valid==0 has no effect.

Reset
REQ-024 rst_n==0 at an edge, from any state including mid-NORM: state <= IDLE; out_valid, out_s, out_e, out_f, out_sat, sh, e <= 0; any in-flight conversion is discarded.
REQ-025 in_ready = 0 while rst_n==0, and 1 from the first cycle after reset releases.
REQ-026 in_valid==1 during reset is not accepted.

Structure
REQ-027 Shared package fpcvt_pkg holds:
- state enum;
- TC_W=12, SM_W=11, E_W=3, F_W=4, E_MAX=7, F_MAX=15, F_RENORM=8.
REQ-028 The sign-magnitude step reuses the existing TCTSM block as the single sub-module instance.
REQ-029 Normalisation and rounding are inline in fpcvt_seq; no other sub-modules.

Verification
REQ-030 Accept in_tc=0x02C (44) -> out_s=0, out_e=2, out_f=11, out_sat=0; out_valid 7 edges after accept.
REQ-031 in_tc=0x02E (46) -> out_e=2, out_f=12 (round up); in_tc=0x07C (124) -> out_e=4, out_f=8 (renormalise).
REQ-032 in_tc=0x7FF -> out_e=7, out_f=15, out_sat=1 after 2 edges; in_tc=0x800 -> out_s=1, out_e=7, out_f=15, out_sat=1.
REQ-033 in_tc=0xFD4 (-44) and 0x00D (13):
- 0xFD4 -> out_s=1, out_e=2, out_f=11;
- 0x00D -> out_e=0, out_f=13 after 9 edges;
- 0x000 -> all zero.
REQ-034 Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0 throughout; pulse out_ready -> IDLE next edge, next sample accepted.
REQ-035 Reset mid-operation: assert rst_n=0 two cycles into NORM for 0x00D -> IDLE with all outputs 0 and no out_valid; a fresh 0x02C then converts per REQ-030.
